lfsr_rng: RTL and testbench

//  Parametrised Fibonacci-LFSR pseudo-random source; next-generation random generator for the tree logic.

---
 rtl/lfsr_rng_if.sv | 23 ++
 rtl/lfsr_rng.sv | 107 ++++++++++
 tb/tb_lfsr_rng.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_rng_if.sv
// lfsr_rng_if: sample handshake between the LFSR random source and its consumer.
//   random     - registered sample (driven by the source)
//   rand_valid - random holds an unconsumed sample (driven by the source)
//   rand_ready - consumer accepts random while rand_valid=1 (driven by the consumer)
interface lfsr_rng_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] random;
  logic             rand_valid;
  logic             rand_ready;

  modport master (
    output random,
    output rand_valid,
    input  rand_ready
  );

  modport slave (
    input  random,
    input  rand_valid,
    output rand_ready
  );
endinterface

// File: rtl/lfsr_rng.sv
// lfsr_rng: parametrised Fibonacci-LFSR pseudo-random source with decimation.
// The LFSR shifts STRIDE times, then spends one cycle capturing its state into a
// single-entry output slot that the consumer drains through a valid/ready handshake.
// Ports:
//   clk, rst     - rising-edge clock, asynchronous active-high reset
//   en           - advance enable; 0 freezes the shift counter and LFSR state
//   seed_load    - load seed_in into the LFSR this cycle (priority over en)
//   seed_in      - seed value; zero selects SEED instead
//   rng          - master side of the sample handshake (random/rand_valid/rand_ready)
//   overrun      - sticky flag: a captured sample was dropped because the slot was full
//   overrun_clr  - clears overrun (a drop in the same cycle wins)
module lfsr_rng #(
  parameter int unsigned     WIDTH  = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
  parameter logic [WIDTH-1:0] SEED  = 8'h0F,
  parameter int unsigned     STRIDE = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  lfsr_rng_if.master       rng,
  output logic             overrun,
  input  logic             overrun_clr
);

  localparam int unsigned CntW = $clog2(STRIDE + 1);

  logic [WIDTH-1:0] state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] random_q, random_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;

  logic fb;
  logic at_capture;
  logic consume;

  assign fb         = ^(state_q & TAPS);
  assign at_capture = (cnt_q == CntW'(STRIDE));
  assign consume    = valid_q & rng.rand_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    random_d  = random_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;

    // LFSR and phase counter
    if (seed_load) begin
      state_d = (seed_in == '0) ? SEED : seed_in;
      cnt_d   = '0;
    end else begin
      if (en) begin
        if (at_capture) begin
          cnt_d = '0;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = {state_q[WIDTH-2:0], fb};
        end
      end
      // All-zero is a fixed point of the XOR feedback; escape it whenever seen.
      if (state_q == '0) begin
        state_d = SEED;
      end
    end

    // Output slot: a consume frees it, a capture in the same cycle refills it.
    if (consume) begin
      valid_d = 1'b0;
    end
    if (overrun_clr) begin
      overrun_d = 1'b0;
    end
    if (en && !seed_load && at_capture) begin
      if (!valid_q || consume) begin
        random_d = state_q;
        valid_d  = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= SEED;
      cnt_q     <= '0;
      random_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      random_q  <= random_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign rng.random     = random_q;
  assign rng.rand_valid = valid_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_lfsr_rng.sv
// tb_lfsr_rng: scoreboard bench for lfsr_rng with default parameters.
// Stimulus pushes expected samples into a queue; a monitor pops one per handshake.
module tb_lfsr_rng;

  logic       clk;
  logic       rst;
  logic       en;
  logic       seed_load;
  logic [7:0] seed_in;
  logic       overrun;
  logic       overrun_clr;

  int n_cmp;
  int n_err;

  logic [7:0] exp_q[$];

  lfsr_rng_if #(.WIDTH(8)) bus ();

  lfsr_rng #(
    .WIDTH (8),
    .TAPS  (8'hB8),
    .SEED  (8'h0F),
    .STRIDE(13)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .seed_load  (seed_load),
    .seed_in    (seed_in),
    .rng        (bus),
    .overrun    (overrun),
    .overrun_clr(overrun_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR: feedback from bits 7,5,4,3.
  function automatic logic [7:0] adv(input logic [7:0] s, input int n);
    logic [7:0] x;
    x = s;
    for (int i = 0; i < n; i++) begin
      x = {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    end
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance n rising edges, landing 2 time units past the last one.
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    en              = 1'b1;
    seed_load       = 1'b0;
    seed_in         = 8'h00;
    overrun_clr     = 1'b0;
    bus.rand_ready  = 1'b0;
    edges(2);
    rst = 1'b0;
  endtask

  // Monitor: one comparison per completed handshake.
  always @(negedge clk) begin
    if (!rst && bus.rand_valid && bus.rand_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_sample: got %0h expected none at %0t", bus.random, $time);
      end else begin
        chk("sample", 32'(bus.random), 32'(exp_q.pop_front()));
        chk("sample_nonzero", 32'(bus.random != 8'h00), 32'd1);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    en    = 1'b1;
    seed_load   = 1'b0;
    seed_in     = 8'h00;
    overrun_clr = 1'b0;
    bus.rand_ready = 1'b0;
    #1;
    chk("rst_random", 32'(bus.random), 32'h0);
    chk("rst_valid", 32'(bus.rand_valid), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);

    // 1: free-running, 256 samples against the reference
    for (int k = 1; k <= 256; k++) exp_q.push_back(adv(8'h0F, 13 * k));
    do_reset();
    bus.rand_ready = 1'b1;
    edges(13);
    chk("first_valid_e13", 32'(bus.rand_valid), 32'h0);
    edges(1);
    chk("first_valid_e14", 32'(bus.rand_valid), 32'h1);
    chk("first_random", 32'(bus.random), 32'hF5);
    for (int i = 0; i < 14 * 256 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    chk("run256_drained", 32'(exp_q.size()), 32'h0);

    // 2: consumer stalled, overrun, clear
    exp_q.delete();
    do_reset();
    edges(14);
    chk("hold_valid", 32'(bus.rand_valid), 32'h1);
    chk("hold_random14", 32'(bus.random), 32'hF5);
    chk("hold_overrun14", 32'(overrun), 32'h0);
    edges(13);
    overrun_clr = 1'b1;
    edges(1);
    overrun_clr = 1'b0;
    chk("overrun_set_wins", 32'(overrun), 32'h1);
    chk("hold_random28", 32'(bus.random), 32'hF5);
    edges(12);
    chk("hold_random40", 32'(bus.random), 32'hF5);
    chk("hold_valid40", 32'(bus.rand_valid), 32'h1);
    overrun_clr = 1'b1;
    edges(1);
    overrun_clr = 1'b0;
    chk("overrun_cleared", 32'(overrun), 32'h0);
    exp_q.push_back(8'hF5);
    exp_q.push_back(adv(8'h0F, 39));
    bus.rand_ready = 1'b1;
    edges(1);
    chk("refill_no_overrun", 32'(overrun), 32'h0);
    chk("refill_valid", 32'(bus.rand_valid), 32'h1);
    edges(1);
    chk("drained_valid", 32'(bus.rand_valid), 32'h0);

    // 3: seed load with zero and nonzero seeds
    do_reset();
    bus.rand_ready = 1'b1;
    exp_q.push_back(8'hF5);
    edges(5);
    seed_load = 1'b1;
    seed_in   = 8'h00;
    edges(1);
    seed_load = 1'b0;
    edges(13);
    chk("seed0_valid_early", 32'(bus.rand_valid), 32'h0);
    edges(1);
    chk("seed0_valid", 32'(bus.rand_valid), 32'h1);
    chk("seed0_random", 32'(bus.random), 32'hF5);
    exp_q.push_back(adv(8'h01, 13));
    seed_load = 1'b1;
    seed_in   = 8'h01;
    edges(1);
    seed_load = 1'b0;
    chk("seed_load_handshake", 32'(bus.rand_valid), 32'h0);
    edges(13);
    chk("seed1_valid_early", 32'(bus.rand_valid), 32'h0);
    edges(1);
    chk("seed1_valid", 32'(bus.rand_valid), 32'h1);
    chk("seed1_random", 32'(bus.random), 32'(adv(8'h01, 13)));
    edges(2);

    // 4: enable gap of 5 cycles delays capture by 5
    do_reset();
    bus.rand_ready = 1'b1;
    exp_q.push_back(8'hF5);
    edges(6);
    en = 1'b0;
    edges(5);
    en = 1'b1;
    edges(7);
    chk("en_gap_valid_early", 32'(bus.rand_valid), 32'h0);
    edges(1);
    chk("en_gap_valid", 32'(bus.rand_valid), 32'h1);
    chk("en_gap_random", 32'(bus.random), 32'hF5);
    edges(2);

    // 5: asynchronous reset mid-phase with a pending sample and overrun
    do_reset();
    edges(29);
    chk("pre_rst_valid", 32'(bus.rand_valid), 32'h1);
    chk("pre_rst_overrun", 32'(overrun), 32'h1);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_random", 32'(bus.random), 32'h0);
    chk("async_rst_valid", 32'(bus.rand_valid), 32'h0);
    chk("async_rst_overrun", 32'(overrun), 32'h0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    bus.rand_ready = 1'b1;
    exp_q.push_back(8'hF5);
    edges(14);
    chk("restart_valid", 32'(bus.rand_valid), 32'h1);
    chk("restart_random", 32'(bus.random), 32'hF5);
    edges(2);
    chk("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
